// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a small prefetch queue: issues word fetches to a
// synchronous instruction memory, buffers returned words with their next-PC, and hands them to decode.
module if_prefetch_stage #(
    parameter int unsigned   DEPTH    = 4,
    parameter int unsigned   AW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter logic [5:0]    HLT_OP   = 6'h3f
) (
    input  logic          clk1,
    input  logic          rst,
    output logic          imem_en,
    output logic [AW-1:0] imem_addr,
    input  logic [31:0]   imem_rdata,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic [31:0]   dec_ir,
    output logic [AW-1:0] dec_npc,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    output logic          halted
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    // Handshake: the head moves to decode on a cycle where dec_valid and dec_ready are both 1;
    // dec_valid never depends on dec_ready.
    logic [AW-1:0] r_pc;
    logic [31:0]   r_q_ir  [DEPTH];
    logic [AW-1:0] r_q_npc [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_inflight;
    logic [AW-1:0] r_inflight_pc;
    logic          r_stop_fetch;
    logic          r_halted;
    logic          r_fetch_ok;
    logic [31:0]   r_last_ir;
    logic [AW-1:0] r_last_npc;

    logic          w_flush;
    logic          w_ret;
    logic          w_ret_hlt;
    logic [CW:0]   w_used;
    logic          w_credit;
    logic          w_issue;
    logic          w_nonempty;
    logic          w_valid;
    logic          w_deq;
    logic          w_head_hlt;

    assign w_flush    = br_taken && !r_halted;
    assign w_ret      = r_inflight && !w_flush;
    // A returning HLT blocks the issue in the same cycle, so nothing past it is ever fetched.
    assign w_ret_hlt  = w_ret && (imem_rdata[31:26] == HLT_OP);
    assign w_used     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
    assign w_credit   = (w_used < (CW+1)'(DEPTH));
    assign w_issue    = r_fetch_ok && !r_stop_fetch && !w_ret_hlt && !r_halted
                        && !br_taken && w_credit;
    assign w_nonempty = (r_count != '0);
    assign w_valid    = w_nonempty && !w_flush;
    assign w_deq      = w_valid && dec_ready;
    assign w_head_hlt = (r_q_ir[r_head][31:26] == HLT_OP);

    assign imem_en    = w_issue;
    assign imem_addr  = r_pc;
    assign dec_valid  = w_valid;
    assign dec_ir     = w_nonempty ? r_q_ir[r_head]  : r_last_ir;
    assign dec_npc    = w_nonempty ? r_q_npc[r_head] : r_last_npc;
    assign halted     = r_halted;

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_stop_fetch  <= 1'b0;
            r_halted      <= 1'b0;
            r_fetch_ok    <= 1'b0;
            r_last_ir     <= '0;
            r_last_npc    <= '0;
        end else begin
            // The first cycle out of reset is idle; fetching starts the cycle after.
            r_fetch_ok <= 1'b1;
            if (w_flush) begin
                r_head       <= '0;
                r_tail       <= '0;
                r_count      <= '0;
                r_inflight   <= 1'b0;
                r_stop_fetch <= 1'b0;
                r_pc         <= br_target;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc          <= r_pc + AW'(1);
                    r_inflight_pc <= r_pc;
                end
                if (w_ret) begin
                    r_tail <= r_tail + PW'(1);
                    if (w_ret_hlt) begin
                        r_stop_fetch <= 1'b1;
                    end
                end
                if (w_deq) begin
                    r_head     <= r_head + PW'(1);
                    r_last_ir  <= r_q_ir[r_head];
                    r_last_npc <= r_q_npc[r_head];
                    if (w_head_hlt) begin
                        r_halted <= 1'b1;
                    end
                end
                r_count <= r_count + CW'(w_ret) - CW'(w_deq);
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (w_ret) begin
            r_q_ir[r_tail]  <= imem_rdata;
            r_q_npc[r_tail] <= r_inflight_pc + AW'(1);
        end
    end

    // The credit check reserves a slot for every outstanding fetch.
    a_no_enq_when_full: assert property (@(posedge clk1) disable iff (rst)
        !(w_ret && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: an address-stream model checks fetch, delivery,
// flush and halt behaviour every cycle; literal expectations pin the scenario timing.
module tb_if_prefetch_stage;
    localparam int DEPTH = 4;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_ir;
    logic [31:0] dec_npc;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        halted;

    logic        imem_en2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2 = '0;
    logic        dec_valid2;
    logic [31:0] dec_ir2;
    logic [31:0] dec_npc2;
    logic        halted2;

    int n_total = 0;
    int n_bad = 0;

    always #5 clk1 = ~clk1;

    if_prefetch_stage #(.DEPTH(DEPTH), .AW(32), .RESET_PC(32'h0)) dut (
        .clk1(clk1), .rst(rst), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_ir(dec_ir), .dec_npc(dec_npc), .br_taken(br_taken),
        .br_target(br_target), .halted(halted));

    if_prefetch_stage #(.DEPTH(DEPTH), .AW(32), .RESET_PC(32'hFFFF_FFFF)) dut_wrap (
        .clk1(clk1), .rst(rst), .imem_en(imem_en2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .dec_valid(dec_valid2), .dec_ready(1'b1),
        .dec_ir(dec_ir2), .dec_npc(dec_npc2), .br_taken(1'b0),
        .br_target(32'h0), .halted(halted2));

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h2801_0078;
            32'd1:   return 32'h0c63_1800;
            32'd2:   return 32'h2022_0000;
            32'd3:   return 32'h0c63_1800;
            32'd4:   return 32'h2842_002d;
            32'd5:   return 32'h0c63_1800;
            32'd6:   return 32'h2422_0001;
            32'd7:   return 32'hfc00_0000;
            default: return {8'h10, a[23:0]};
        endcase
    endfunction

    always @(posedge clk1) begin
        if (imem_en)  imem_rdata  <= mem_word(imem_addr);
        if (imem_en2) imem_rdata2 <= mem_word(imem_addr2);
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard / model ----------------
    logic [31:0] m_fetch, m_deliv, m_last_ir, m_last_npc;
    int          m_out;
    logic        m_inflight, m_stop, m_halted, m_post, m_flushed;
    logic [31:0] exp_q[$];
    int          cyc, n_issue, n_deliv, first_hs_cyc, last_hs_cyc, issue4_cyc;
    logic [31:0] max_issue, aflush_ir, aflush_npc;
    logic        aflush_got, saw5;

    always @(negedge clk1) begin
        logic        flush, exp_en, exp_valid, issued;
        logic [31:0] w, e;
        if (rst) begin
            m_fetch = 0; m_deliv = 0; m_last_ir = 0; m_last_npc = 0;
            m_out = 0; m_inflight = 0; m_stop = 0; m_halted = 0; m_post = 1;
            m_flushed = 0; exp_q.delete();
            cyc = 0; n_issue = 0; n_deliv = 0; first_hs_cyc = 0; last_hs_cyc = 0;
            issue4_cyc = 0; max_issue = 0; aflush_got = 0; saw5 = 0;
            aflush_ir = 0; aflush_npc = 0;
        end else begin
            cyc++;
            flush     = br_taken && !m_halted;
            exp_en    = (m_out < DEPTH) && !m_stop && !m_halted && !br_taken && !m_post;
            exp_valid = ((m_out - int'(m_inflight)) > 0) && !flush;
            chk("halted", {31'd0, halted}, {31'd0, m_halted});
            chk("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
            chk("dec_valid", {31'd0, dec_valid}, {31'd0, exp_valid});
            issued = 1'b0;
            if (imem_en && exp_en) begin
                chk("imem_addr", imem_addr, m_fetch);
                issued = 1'b1;
                n_issue++;
                if (imem_addr > max_issue) max_issue = imem_addr;
                if (imem_addr == 32'd4 && issue4_cyc == 0) issue4_cyc = cyc;
                w = mem_word(m_fetch);
                if (w[31:26] == 6'h3f) m_stop = 1;
                exp_q.push_back(m_fetch);
                m_fetch = m_fetch + 1;
                m_out++;
            end
            if (dec_valid && exp_valid && dec_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : m_deliv;
                w = mem_word(e);
                chk("dec_ir", dec_ir, w);
                chk("dec_npc", dec_npc, e + 1);
                if (dec_ir == 32'h0c63_1800 && dec_npc == 32'd6) saw5 = 1;
                if (m_flushed && !aflush_got) begin
                    aflush_got = 1; aflush_ir = dec_ir; aflush_npc = dec_npc;
                end
                if (first_hs_cyc == 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
                if (w[31:26] == 6'h3f) m_halted = 1;
                m_last_ir = w; m_last_npc = e + 1;
                m_deliv = e + 1;
                m_out--;
                n_deliv++;
            end else if (!dec_valid && !br_taken) begin
                chk("hold_ir", dec_ir, m_last_ir);
                chk("hold_npc", dec_npc, m_last_npc);
            end
            m_inflight = issued;
            if (flush) begin
                m_fetch = br_target; m_deliv = br_target; m_out = 0;
                m_inflight = 0; m_stop = 0; m_flushed = 1; exp_q.delete();
            end
            m_post = 0;
        end
    end

    // Wrap instance: first two fetch addresses and first delivered word.
    logic [31:0] a2_0, a2_1, hs2_ir, hs2_npc;
    int          n2_issue;
    logic        hs2_got;
    always @(negedge clk1) begin
        if (rst) begin
            n2_issue = 0; hs2_got = 0; a2_0 = 0; a2_1 = 0; hs2_ir = 0; hs2_npc = 0;
        end else begin
            if (imem_en2) begin
                if (n2_issue == 0) a2_0 = imem_addr2;
                if (n2_issue == 1) a2_1 = imem_addr2;
                n2_issue++;
            end
            if (dec_valid2 && !hs2_got) begin
                hs2_got = 1; hs2_ir = dec_ir2; hs2_npc = dec_npc2;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_reset();
        @(posedge clk1); #1 rst = 1'b1; br_taken = 1'b0;
        @(posedge clk1); #1 rst = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic wait_deliv(input int n);
        int k;
        for (k = 0; k < 60 && n_deliv < n; k++) @(posedge clk1);
        #1;
        if (n_deliv < n) begin
            n_total++; n_bad++;
            $display("FAIL wait_deliv got=%0d exp=%0d", n_deliv, n);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Straight-line program ending in HLT.
        dec_ready = 1'b1;
        do_reset();
        run(20);
        chk("t1_deliveries", n_deliv, 8);
        chk("t1_first_hs_cyc", first_hs_cyc, 4);
        chk("t1_last_hs_cyc", last_hs_cyc, 11);
        chk("t1_issues", n_issue, 8);
        chk("t1_max_addr", max_issue, 7);
        chk("t1_halted", {31'd0, halted}, 1);
        chk("wrap_addr0", a2_0, 32'hFFFF_FFFF);
        chk("wrap_addr1", a2_1, 32'h0000_0000);
        chk("wrap_ir", hs2_ir, 32'h10FF_FFFF);
        chk("wrap_npc", hs2_npc, 32'h0);

        // Back-pressure: queue fills, then drains in order.
        dec_ready = 1'b0;
        do_reset();
        run(10);
        chk("t2_issues_stalled", n_issue, 4);
        chk("t2_en_idle", {31'd0, imem_en}, 0);
        dec_ready = 1'b1;
        run(20);
        chk("t2_first_hs_cyc", first_hs_cyc, 11);
        chk("t2_issue4_cyc", issue4_cyc, 12);
        chk("t2_deliveries", n_deliv, 8);
        chk("t2_halted", {31'd0, halted}, 1);

        // Branch flush with 2..4 queued and 5 in flight.
        dec_ready = 1'b1;
        do_reset();
        wait_deliv(2);
        dec_ready = 1'b0;
        run(2);
        br_taken = 1'b1; br_target = 32'd6; dec_ready = 1'b1;
        @(negedge clk1);
        chk("t3_valid_in_flush", {31'd0, dec_valid}, 0);
        chk("t3_en_in_flush", {31'd0, imem_en}, 0);
        @(posedge clk1); #1 br_taken = 1'b0;
        run(15);
        chk("t3_next_ir", aflush_ir, 32'h2422_0001);
        chk("t3_next_npc", aflush_npc, 32'd7);
        chk("t3_no_word5", {31'd0, saw5}, 0);
        chk("t3_halted", {31'd0, halted}, 1);

        // HLT queued but not accepted, then redirect to 0.
        dec_ready = 1'b1;
        do_reset();
        wait_deliv(5);
        dec_ready = 1'b0;
        run(8);
        chk("t4_stopped", {31'd0, imem_en}, 0);
        br_taken = 1'b1; br_target = 32'd0;
        @(posedge clk1); #1 br_taken = 1'b0;
        @(negedge clk1);
        chk("t4_restart_en", {31'd0, imem_en}, 1);
        chk("t4_restart_addr", imem_addr, 32'd0);
        chk("t4_not_halted", {31'd0, halted}, 0);
        dec_ready = 1'b1;
        run(25);
        chk("t4_deliveries", n_deliv, 13);
        chk("t4_halted", {31'd0, halted}, 1);

        // Reset with a full queue.
        dec_ready = 1'b0;
        do_reset();
        run(10);
        rst = 1'b1;
        @(posedge clk1); #1 rst = 1'b0;
        @(negedge clk1);
        chk("t5_valid", {31'd0, dec_valid}, 0);
        chk("t5_halted", {31'd0, halted}, 0);
        chk("t5_en", {31'd0, imem_en}, 0);
        @(negedge clk1);
        chk("t5_en_next", {31'd0, imem_en}, 1);
        chk("t5_addr_next", imem_addr, 32'd0);

        run(2);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
